dither_packer: RTL
==================

Name: dither_packer

Overview:
- Downstream stage of the ordered dithering block. Consumes its registered 16-bit output of four 4-bit pixels, first pixel in bits [15:12].
- Packs PACK_WORDS consecutive dithered words into one wide word and buffers it in a small FIFO for the framebuffer write path.
- Line and frame boundaries are carried through as sideband flags. The input is a free-running video stream with no ready; overflow is detected and flagged.

Parameters:
- LAT, 1: cycles between in_valid/in_eol/in_eof assertion and the matching din; matches dither latency.
- PACK_WORDS, 4: 16-bit words per output word; legal values 2, 4, 8.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- PAD_NIBBLE, 4'hF: pixel value used to fill a partial word at end of line.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; logic resets on clk edge while rst==0.
- din  input  16  dithered pixels {p0,p1,p2,p3}, valid LAT cycles after in_valid.
- in_valid  input  1  qualifier, aligned with the dither block's vin.
- in_eol  input  1  last word of line; qualified by in_valid; same alignment as in_valid.
- in_eof  input  1  last word of frame; only meaningful with in_eol.
- dout  output  16*PACK_WORDS  packed word; earliest input word in the MSBs.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts dout when out_valid && out_ready.
- out_last  output  1  dout closes a line.
- out_frame  output  1  dout closes a frame.
- overflow  output  1  sticky: a packed word was dropped.

Behaviour:
- Reset (rst==0 at clk edge):
  - cnt=0, accumulator=0, delay line cleared.
  - FIFO empty, out_valid=0, dout=0, out_last=0, out_frame=0, overflow=0.
- Alignment:
  - in_valid, in_eol and in_eof pass through a LAT-stage delay line, giving v_d, eol_d, eof_d.
  - din is sampled when v_d==1.
- Pack state:
  - cnt counts 0..PACK_WORDS-1.
  - Each sampled word is written into slot cnt; slot 0 occupies the MSBs.
- Push conditions (one push per cycle maximum):
  - cnt==PACK_WORDS-1 on a sampled word: push the full word, cnt returns to 0.
  - eol_d on a sampled word with cnt<PACK_WORDS-1: fill unwritten slots with PAD_NIBBLE in every nibble, push, cnt returns to 0.
  - out_last=eol_d and out_frame=eol_d&&eof_d are stored with the word.
  - eol_d when the word is also full: a single push with last set, no extra padded word.
- eof_d without eol_d is ignored.
- FIFO behaviour:
  - First-in first-out, registered storage; dout, out_last and out_frame are driven from the head entry.
  - Pop on out_valid && out_ready.
  - Push-to-out_valid latency is 1 cycle. Total latency from sampled din to out_valid is 1 cycle when the FIFO was empty.
  - When empty, dout, out_last and out_frame hold their last values and are don't-care.
  - Push and pop in the same cycle is allowed at any level, including full, and the level is unchanged.
  - Push when full with no pop: the word is dropped, the FIFO is unchanged, overflow is set until reset. Pack state still resets to cnt=0.
  - Pointers wrap modulo FIFO_DEPTH; a level counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Reset mid-line discards the partial word and any in-flight delay-line entries.
- No combinational path from out_ready to out_valid.

Optional Feature:
- Macro: DITHER_PACKER_STATS_EN.
- When defined, add the following output ports:
  - drop_count  output  16: count of dropped words, saturating at 16'hFFFF.
  - frame_words  output  16: number of words pushed in the last completed frame; updated on the push carrying out_frame.
  - Both are 0 at reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- LAT=1, PACK_WORDS=4; feed 4 words 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, with eol on the last, out_ready=1 -> one word 64'h0123456789ABCDEF with out_last=1, out_frame=0, out_valid high 1 cycle after the 4th din.
- Partial line: 2 words 16'h1111, 16'h2222, eol+eof on the 2nd -> 64'h11112222FFFFFFFF, out_last=1, out_frame=1.
- Backpressure: out_ready=0, 5 full words pushed into FIFO_DEPTH=4 -> first 4 retained in order, overflow=1 after the 5th push. Release out_ready -> exactly 4 words pop in order, overflow stays 1.
- Full-FIFO simultaneous push/pop: FIFO full with out_ready=1 during a push -> no drop, overflow=0, order preserved.
- Reset mid-line: 3 words, then rst=0 for 1 cycle, then 4 fresh words -> only the packed fresh word appears, and all outputs read 0 during reset.
- With DITHER_PACKER_STATS_EN: frame of 10 lines, 4 words per line -> frame_words=10. Forced 3 drops -> drop_count=3.

Source files
------------

// File: rtl/dither_packer.sv
// dither_packer: packs dithered 16-bit pixel words into wide words and queues them in a FIFO; DITHER_PACKER_STATS_EN adds drop/frame counters
module dither_packer #(
  parameter int         LAT        = 1,
  parameter int         PACK_WORDS = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] PAD_NIBBLE = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             din,
  input  logic                    in_valid,
  input  logic                    in_eol,
  input  logic                    in_eof,
  output logic [16*PACK_WORDS-1:0] dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_frame,
  output logic                    overflow
`ifdef DITHER_PACKER_STATS_EN
  ,
  output logic [15:0]             drop_count,
  output logic [15:0]             frame_words
`endif
);
  localparam int W  = 16 * PACK_WORDS;
  localparam int CW = $clog2(PACK_WORDS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2:0]    dly_q [LAT];
  logic          v_d, eol_d, eof_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_nxt, pword;
  logic [W+1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   lvl_q;
  logic          ovf_q, push, pop, full, wr;
  assign {v_d, eol_d, eof_d} = dly_q[LAT-1];
  always_comb begin
    acc_nxt = acc_q;
    pword   = acc_q;
    for (int s = 0; s < PACK_WORDS; s++) begin
      acc_nxt[W-16*(s+1) +: 16] = (s == int'(cnt_q)) ? din : acc_q[W-16*(s+1) +: 16];
      pword[W-16*(s+1) +: 16]   = (s > int'(cnt_q)) ? {4{PAD_NIBBLE}} : acc_nxt[W-16*(s+1) +: 16];
    end
  end
  assign push      = v_d && (cnt_q == CW'(PACK_WORDS - 1) || eol_d);
  assign cnt_d     = !v_d ? cnt_q : push ? '0 : cnt_q + 1'b1;
  assign out_valid = lvl_q != '0;
  assign pop       = out_valid && out_ready;
  assign full      = lvl_q == (AW+1)'(FIFO_DEPTH);
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push
  assign wr        = push && (!full || pop);
  assign {dout, out_last, out_frame} = mem_q[rp_q];
  assign overflow  = ovf_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_q <= '{default: '0};
      cnt_q <= '0;
      acc_q <= '0;
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dly_q[0] <= {in_valid, in_eol, in_eof};
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      if (v_d) acc_q <= acc_nxt;
      cnt_q <= cnt_d;
      if (wr) begin
        mem_q[wp_q] <= {pword, eol_d, eol_d && eof_d};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      if (wr && !pop) lvl_q <= lvl_q + 1'b1;
      else if (pop && !wr) lvl_q <= lvl_q - 1'b1;
      if (push && !wr) ovf_q <= 1'b1;
    end
  end
`ifdef DITHER_PACKER_STATS_EN
  logic [15:0] drop_q, fw_q, fcnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
      fw_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push && !wr && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      if (wr) fcnt_q <= (eol_d && eof_d) ? '0 : fcnt_q + 1'b1;
      if (wr && eol_d && eof_d) fw_q <= fcnt_q + 1'b1;
    end
  end
  assign drop_count  = drop_q;
  assign frame_words = fw_q;
`endif
endmodule
